// File: rtl/matrix_axis_stream_harness.sv
// Stream harness around the matrix kernel: sources in_A, sinks out_C, counts
// beats, checksums the result and flags a hang when neither stream progresses.
module matrix_axis_stream_harness #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned N_IN    = 64,
    parameter int unsigned N_OUT   = 64,
    parameter int unsigned SEED    = 0,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              start,
    input  logic              src_en,
    input  logic              snk_en,
    output logic [DATA_W-1:0] in_A_TDATA,
    output logic              in_A_TVALID,
    output logic              in_A_TLAST,
    input  logic              in_A_TREADY,
    input  logic [DATA_W-1:0] out_C_TDATA,
    input  logic              out_C_TVALID,
    input  logic              out_C_TLAST,
    output logic              out_C_TREADY,
    output logic              busy,
    output logic              done,
    output logic              deadlock,
    output logic [15:0]       in_cnt,
    output logic [15:0]       out_cnt,
    output logic [DATA_W-1:0] checksum,
    output logic              last_err
);

    localparam logic [15:0]       N_IN_C    = 16'(N_IN);
    localparam logic [15:0]       N_OUT_C   = 16'(N_OUT);
    localparam logic [15:0]       N_IN_M1   = 16'(N_IN - 1);
    localparam logic [15:0]       N_OUT_M1  = 16'(N_OUT - 1);
    localparam logic [15:0]       TIMEOUT_C = 16'(TIMEOUT);
    localparam logic [DATA_W-1:0] SEED_W    = DATA_W'(SEED);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_HANG = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] wdog;
    logic        run;
    logic        src_hs, snk_hs;
    logic        restart;
    logic [15:0] in_cnt_nxt, out_cnt_nxt;

    assign run          = (state == S_RUN);
    assign in_A_TVALID  = run & src_en & (in_cnt < N_IN_C);
    assign in_A_TDATA   = SEED_W + DATA_W'(in_cnt);
    assign in_A_TLAST   = (in_cnt == N_IN_M1);
    assign out_C_TREADY = run & snk_en & (out_cnt < N_OUT_C);

    assign src_hs      = in_A_TVALID & in_A_TREADY;
    assign snk_hs      = out_C_TREADY & out_C_TVALID;
    assign restart     = start & ~run;
    assign in_cnt_nxt  = in_cnt + {15'd0, src_hs};
    assign out_cnt_nxt = out_cnt + {15'd0, snk_hs};

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                // Completion wins over a watchdog expiry landing on the same edge.
                if (in_cnt_nxt == N_IN_C && out_cnt_nxt == N_OUT_C)
                    state_nxt = S_DONE;
                else if (wdog == TIMEOUT_C)
                    state_nxt = S_HANG;
            end
            default: begin
                if (start)
                    state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            deadlock <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt == S_RUN);
            done     <= (state_nxt == S_DONE);
            deadlock <= (state_nxt == S_HANG);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            in_cnt   <= '0;
            out_cnt  <= '0;
            checksum <= '0;
            last_err <= 1'b0;
            wdog     <= '0;
        end else if (restart) begin
            in_cnt   <= '0;
            out_cnt  <= '0;
            checksum <= '0;
            last_err <= 1'b0;
            wdog     <= '0;
        end else if (run) begin
            in_cnt  <= in_cnt_nxt;
            out_cnt <= out_cnt_nxt;
            if (snk_hs) begin
                checksum <= checksum + out_C_TDATA;
                if (out_C_TLAST != (out_cnt == N_OUT_M1))
                    last_err <= 1'b1;
            end
            // Idle-throttled cycles hold the watchdog instead of aging it.
            if (src_hs || snk_hs)
                wdog <= '0;
            else if (in_A_TVALID || out_C_TREADY)
                wdog <= wdog + 16'd1;
        end
    end

endmodule

// File: doc/matrix_axis_stream_harness.md
# matrix_axis_stream_harness

Stream-side counterpart to the matrix kernel's AXI-Stream ports. It drives `in_A` as an AXI-Stream master, sinks `out_C` as an AXI-Stream slave, and counts words and checksums the result. A watchdog declares a hang when neither stream makes progress. The block sits in the simulation and on-board test wrapper around the HLS matrix kernel, which lets the stall events that the kernel deadlock monitor flags be reproduced and measured deterministically.

## Interface
Parameters:
- `DATA_W`, 32: TDATA width of both streams.
- `N_IN`, 64: beats sent on `in_A` per run (8x8 matrix).
- `N_OUT`, 64: beats expected on `out_C` per run.
- `SEED`, 0: value of the first source word.
- `TIMEOUT`, 1024: consecutive no-progress cycles before a hang is declared; legal range 2..65535.

Ports:
- `ap_clk`, in, 1: single clock; all logic is rising-edge.
- `ap_rst_n`, in, 1: reset, asynchronous assert, active-low.
- `start`, in, 1: one-cycle pulse that begins a run.
- `src_en`, in, 1: source throttle; 0 forces `in_A_TVALID` low.
- `snk_en`, in, 1: sink throttle; 0 forces `out_C_TREADY` low.
- `in_A_TDATA`, out, DATA_W: source data.
- `in_A_TVALID`, out, 1: source valid.
- `in_A_TLAST`, out, 1: high on beat N_IN-1.
- `in_A_TREADY`, in, 1: kernel ready.
- `out_C_TDATA`, in, DATA_W: result data.
- `out_C_TVALID`, in, 1: result valid.
- `out_C_TLAST`, in, 1: result last.
- `out_C_TREADY`, out, 1: sink ready.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: high in DONE.
- `deadlock`, out, 1: high in HANG.
- `in_cnt`, out, 16: beats sent this run.
- `out_cnt`, out, 16: beats received this run.
- `checksum`, out, DATA_W: sum of received TDATA, mod 2^DATA_W.
- `last_err`, out, 1: sticky; set on a misplaced or missing TLAST.

## Operation
- FSM states: IDLE, RUN, DONE, HANG. Reset state is IDLE.
- Transitions:
  - IDLE, DONE or HANG to RUN when `start`=1. On that edge, all counters, `checksum`, `last_err` and the watchdog clear to 0.
  - RUN to DONE when `in_cnt`==N_IN and `out_cnt`==N_OUT after the current handshakes are applied.
  - RUN to HANG when the watchdog reaches TIMEOUT.
  - `start` in RUN is ignored.
- Source:
  - `in_A_TVALID` = RUN & `src_en` & (`in_cnt` < N_IN).
  - `in_A_TDATA` = SEED + `in_cnt`, mod 2^DATA_W.
  - `in_A_TLAST` = (`in_cnt` == N_IN-1).
  - A beat transfers when TVALID & TREADY; `in_cnt` then increments.
  - Data is stable while TVALID=1 and TREADY=0. It can only change on a transfer, because it is derived from `in_cnt`.
  - Dropping `src_en` mid-beat is the only permitted retraction of TVALID. It is a test-only violation, driven by the bench.
- Sink:
  - `out_C_TREADY` = RUN & `snk_en` & (`out_cnt` < N_OUT).
  - On each transfer: `checksum` += TDATA and `out_cnt` increments.
  - `last_err` is set if TLAST=1 on a beat with `out_cnt` != N_OUT-1, or TLAST=0 on beat N_OUT-1.
  - Beats beyond N_OUT are not accepted, because TREADY is low.
- Watchdog:
  - In RUN, a 16-bit counter increments on cycles where (`in_A_TVALID` | `out_C_TREADY`) = 1 and no handshake occurs on either stream.
  - It clears on any handshake.
  - It holds when both sides are throttled off.
  - Source and sink handshakes in the same cycle are both counted; the watchdog clears.

## Timing
- All outputs are registered except the TVALID, TREADY, TDATA and TLAST terms, which are decoded from registered state and counters.
- Reset values:
  - State is IDLE.
  - `busy`, `done`, `deadlock`, `last_err`, `in_A_TVALID`, `out_C_TREADY` are 0.
  - `in_cnt`, `out_cnt`, `checksum` are 0.
  - `in_A_TDATA` = SEED.
- `start` sampled at edge k gives `busy`=1 and `in_A_TVALID`=1 (if `src_en`) in cycle k+1.
- `done` rises the cycle after the final handshake.
- `deadlock` rises the cycle after the watchdog count equals TIMEOUT, i.e. TIMEOUT stalled cycles after the last progress.
- Reset asserted mid-run immediately forces the reset values. No partial beat is retained.
- Full throughput is one beat per cycle per stream when the partner holds its handshake signal high.

## Test plan
- N_IN=N_OUT=4, SEED=0x10, loopback kernel model with ready and valid always high:
  - `in_A` carries 0x10..0x13, with TLAST on the 4th beat.
  - Sink gets 4 beats and `checksum`=0x46.
  - `done`=1 at cycle 5 after start, and `last_err`=0.
- Kernel TREADY toggled 1,0,1,0:
  - TDATA holds during each low cycle.
  - `in_cnt` reaches 4 with no duplicated or skipped word.
  - `deadlock`=0.
- TIMEOUT=16 with kernel TREADY=0 and out_C_TVALID=0 forever:
  - `deadlock`=1 exactly 17 cycles after `busy` rises.
  - `done`=0.
  - `in_cnt`=0.
- Output model asserts TLAST on beat 2 of 4:
  - `last_err`=1 from the cycle after beat 2.
  - Run still completes with `done`=1.
- Reset mid-run after 2 beats, then `start`:
  - All outputs take their reset values asynchronously.
  - Restarted run begins at TDATA=SEED.
  - `checksum` matches the clean run.
- `snk_en`=0 and `src_en`=0 for 100 cycles in RUN, then both set to 1:
  - No hang is declared.
  - Run finishes with `done`=1.
